router_pkt_tx: RTL and testbench



---
 rtl/router_pkt_pkg.sv | 21 ++
 rtl/router_pkt_buf.sv | 45 ++++
 rtl/router_pkt_tx.sv | 186 ++++++++++++++++++
 tb/tb_router_pkt_tx.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/router_pkt_pkg.sv
// Shared types and helpers for the router packet transmitter.
// Header byte layout is {len[5:0], addr[1:0]}.
package router_pkt_pkg;

    localparam int LEN_W = 6;
    localparam logic [1:0] ADDR_ILLEGAL = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_HDR,
        ST_PAY,
        ST_PAR,
        ST_GAP
    } state_t;

    function automatic logic [7:0] pack_header(input logic [LEN_W-1:0] len, input logic [1:0] addr);
        return {len, addr};
    endfunction

endpackage

// File: rtl/router_pkt_buf.sv
// Payload buffer: synchronous write, asynchronous read, with write/read pointers.
// Pointers clear on reset or whenever the transmitter is idle.
module router_pkt_buf #(
    parameter int DEPTH = 64,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             wr_en,
    input  logic [7:0]       wr_data,
    input  logic             rd_adv,
    output logic [PTR_W-1:0] wptr,
    output logic [PTR_W-1:0] rptr,
    output logic [7:0]       rd_data,
    output logic [7:0]       rd_ahead
);

    logic [7:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wptr] <= wr_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (wr_en) begin
                wptr <= wptr + PTR_W'(1);
            end
            if (rd_adv) begin
                rptr <= rptr + PTR_W'(1);
            end
        end
    end

    // rd_ahead lets the registered output load the next byte on the consuming edge.
    assign rd_data  = mem[rptr];
    assign rd_ahead = mem[rptr + PTR_W'(1)];

endmodule

// File: rtl/router_pkt_tx.sv
// Packet transmitter: buffers a request's payload, then sends header, payload, parity.
// Optional macro PKT_TX_PARITY_ERR_EN adds corrupt_parity to force a parity error.
module router_pkt_tx
    import router_pkt_pkg::*;
#(
    parameter int GAP_CYCLES = 1,
    parameter int MAX_LEN    = 63
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             req_valid,
    input  logic [1:0]       req_addr,
    input  logic [LEN_W-1:0] req_len,
    output logic             req_ready,
    input  logic             pl_valid,
    input  logic [7:0]       pl_data,
    output logic             pl_ready,
    input  logic             busy,
    output logic [7:0]       data_out,
    output logic             pkt_valid,
    output logic             byte_valid,
    output logic             done,
    output logic             bad_req
`ifdef PKT_TX_PARITY_ERR_EN
    ,
    input  logic             corrupt_parity
`endif
);

    localparam logic [3:0] GAP_LAST = 4'(GAP_CYCLES - 1);

    state_t           state_reg;
    logic [7:0]       hdr_reg;
    logic [LEN_W-1:0] len_reg;
    logic [7:0]       par_reg;
    logic [3:0]       gap_cnt_reg;
    logic [7:0]       par_emit;
    logic [LEN_W-1:0] wptr;
    logic [LEN_W-1:0] rptr;
    logic [7:0]       rd_data;
    logic [7:0]       rd_ahead;
    logic             wr_en;
    logic             rd_adv;
    logic             last_pay;
    logic             last_load;
    logic             req_fire;

`ifdef PKT_TX_PARITY_ERR_EN
    logic corrupt_reg;

    always_ff @(posedge clock) begin
        if (reset) begin
            corrupt_reg <= 1'b0;
        end else if (state_reg == ST_IDLE && req_fire && req_addr != ADDR_ILLEGAL) begin
            corrupt_reg <= corrupt_parity;
        end
    end

    assign par_emit = par_reg ^ {7'b0, corrupt_reg};
`else
    assign par_emit = par_reg;
`endif

    assign req_fire  = req_valid && req_ready;
    assign wr_en     = (state_reg == ST_LOAD) && pl_valid && pl_ready;
    assign last_load = (wptr == len_reg - LEN_W'(1));
    assign last_pay  = (rptr == len_reg - LEN_W'(1));
    assign rd_adv    = (state_reg == ST_PAY) && !busy && !last_pay;

    router_pkt_buf #(
        .DEPTH (MAX_LEN + 1),
        .PTR_W (LEN_W)
    ) u_buf (
        .clock    (clock),
        .reset    (reset),
        .clear    (state_reg == ST_IDLE),
        .wr_en    (wr_en),
        .wr_data  (pl_data),
        .rd_adv   (rd_adv),
        .wptr     (wptr),
        .rptr     (rptr),
        .rd_data  (rd_data),
        .rd_ahead (rd_ahead)
    );

    // Outputs are loaded with the values of the state being entered.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg   <= ST_IDLE;
            hdr_reg     <= '0;
            len_reg     <= '0;
            par_reg     <= '0;
            gap_cnt_reg <= '0;
            data_out    <= '0;
            pkt_valid   <= 1'b0;
            byte_valid  <= 1'b0;
            done        <= 1'b0;
            bad_req     <= 1'b0;
            req_ready   <= 1'b1;
            pl_ready    <= 1'b0;
        end else begin
            done    <= 1'b0;
            bad_req <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (req_fire) begin
                        if (req_addr == ADDR_ILLEGAL) begin
                            bad_req <= 1'b1;
                        end else begin
                            hdr_reg   <= pack_header(req_len, req_addr);
                            par_reg   <= pack_header(req_len, req_addr);
                            len_reg   <= req_len;
                            req_ready <= 1'b0;
                            if (req_len != '0) begin
                                state_reg <= ST_LOAD;
                                pl_ready  <= 1'b1;
                            end else begin
                                state_reg  <= ST_HDR;
                                data_out   <= pack_header(req_len, req_addr);
                                pkt_valid  <= 1'b1;
                                byte_valid <= 1'b1;
                            end
                        end
                    end
                end
                ST_LOAD: begin
                    if (wr_en) begin
                        par_reg <= par_reg ^ pl_data;
                        if (last_load) begin
                            state_reg  <= ST_HDR;
                            pl_ready   <= 1'b0;
                            data_out   <= hdr_reg;
                            pkt_valid  <= 1'b1;
                            byte_valid <= 1'b1;
                        end
                    end
                end
                ST_HDR: begin
                    if (!busy) begin
                        if (len_reg != '0) begin
                            state_reg <= ST_PAY;
                            data_out  <= rd_data;
                        end else begin
                            state_reg <= ST_PAR;
                            data_out  <= par_emit;
                            pkt_valid <= 1'b0;
                        end
                    end
                end
                ST_PAY: begin
                    if (!busy) begin
                        if (last_pay) begin
                            state_reg <= ST_PAR;
                            data_out  <= par_emit;
                            pkt_valid <= 1'b0;
                        end else begin
                            data_out <= rd_ahead;
                        end
                    end
                end
                ST_PAR: begin
                    if (!busy) begin
                        state_reg   <= ST_GAP;
                        done        <= 1'b1;
                        data_out    <= '0;
                        byte_valid  <= 1'b0;
                        gap_cnt_reg <= '0;
                    end
                end
                ST_GAP: begin
                    if (gap_cnt_reg == GAP_LAST) begin
                        state_reg <= ST_IDLE;
                        req_ready <= 1'b1;
                    end else begin
                        gap_cnt_reg <= gap_cnt_reg + 4'd1;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                    req_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_router_pkt_tx.sv
// Self-checking bench for router_pkt_tx: a packet-level model predicts the byte stream,
// a per-cycle monitor compares against it, and directed tests pin literal values.
module tb_router_pkt_tx;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       req_valid = 1'b0;
    logic [1:0] req_addr = 2'd0;
    logic [5:0] req_len = 6'd0;
    logic       req_ready;
    logic       pl_valid = 1'b0;
    logic [7:0] pl_data = 8'd0;
    logic       pl_ready;
    logic       busy = 1'b0;
    logic [7:0] data_out;
    logic       pkt_valid;
    logic       byte_valid;
    logic       done;
    logic       bad_req;
    logic       corrupt_parity = 1'b0;

    router_pkt_tx dut (
        .clock      (clock),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_addr   (req_addr),
        .req_len    (req_len),
        .req_ready  (req_ready),
        .pl_valid   (pl_valid),
        .pl_data    (pl_data),
        .pl_ready   (pl_ready),
        .busy       (busy),
        .data_out   (data_out),
        .pkt_valid  (pkt_valid),
        .byte_valid (byte_valid),
        .done       (done),
        .bad_req    (bad_req)
`ifdef PKT_TX_PARITY_ERR_EN
        ,
        .corrupt_parity (corrupt_parity)
`endif
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [7:0] b;
        logic       pv;
        logic       last;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] pay_q[$];
    int         errors = 0;
    int         checks = 0;
    int         byte_idx = 0;
    int         bv_cycles = 0;
    int         pl_ready_cycles = 0;
    int         busy_plan[0:79];
    logic       done_exp = 1'b0;
    logic       bad_exp = 1'b0;
    logic [7:0] last_par = 8'h00;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: every cycle out of reset, outputs must match the packet model.
    always @(negedge clock) begin
        if (reset) begin
            done_exp = 1'b0;
            bad_exp  = 1'b0;
        end else begin
            check("done", done, done_exp);
            check("bad_req", bad_req, bad_exp);
            done_exp = 1'b0;
            bad_exp  = 1'b0;
            if (pl_ready) pl_ready_cycles++;
            if (byte_valid) begin
                bv_cycles++;
                if (exp_q.size() == 0) begin
                    check("unexpected_byte", 1, 0);
                end else begin
                    check("data_out", data_out, exp_q[0].b);
                    check("pkt_valid", pkt_valid, exp_q[0].pv);
                    if (!busy) begin
                        if (exp_q[0].last) begin
                            done_exp = 1'b1;
                            last_par = data_out;
                        end
                        void'(exp_q.pop_front());
                        byte_idx++;
                    end
                end
            end
        end
    end

    // Back-pressure driver: hold busy for the planned number of cycles on each byte.
    always @(posedge clock) begin
        #2;
        if (byte_valid && byte_idx < 80 && busy_plan[byte_idx] > 0) begin
            busy = 1'b1;
            busy_plan[byte_idx] = busy_plan[byte_idx] - 1;
        end else begin
            busy = 1'b0;
        end
    end

    task automatic send_pkt(input logic [1:0] a, input logic [5:0] l, input logic corrupt);
        logic [7:0] par;
        int         n;
        byte_idx  = 0;
        bv_cycles = 0;
        if (a != 2'b11) begin
            par = {l, a};
            exp_q.push_back('{b: {l, a}, pv: 1'b1, last: 1'b0});
            for (int i = 0; i < int'(l); i++) begin
                par = par ^ pay_q[i];
                exp_q.push_back('{b: pay_q[i], pv: 1'b1, last: 1'b0});
            end
            if (corrupt) par = par ^ 8'h01;
            exp_q.push_back('{b: par, pv: 1'b0, last: 1'b1});
        end
        n = 0;
        while (!req_ready && n < 200) begin
            @(posedge clock);
            #2;
            n++;
        end
        if (!req_ready) check("req_ready_timeout", 0, 1);
        req_valid      = 1'b1;
        req_addr       = a;
        req_len        = l;
        corrupt_parity = corrupt;
        @(posedge clock);
        #2;
        req_valid      = 1'b0;
        corrupt_parity = 1'b0;
        if (a == 2'b11) begin
            bad_exp = 1'b1;
        end else begin
            for (int i = 0; i < int'(l); i++) begin
                n = 0;
                while (!pl_ready && n < 200) begin
                    @(posedge clock);
                    #2;
                    n++;
                end
                if (!pl_ready) check("pl_ready_timeout", 0, 1);
                pl_valid = 1'b1;
                pl_data  = pay_q[i];
                @(posedge clock);
                #2;
            end
            pl_valid = 1'b0;
        end
    endtask

    task automatic wait_done();
        for (int i = 0; i < 400 && exp_q.size() != 0; i++) @(posedge clock);
        if (exp_q.size() != 0) begin
            check("packet_timeout", exp_q.size(), 0);
            exp_q.delete();
        end
        repeat (2) @(posedge clock);
        #2;
        check("req_ready_after_gap", req_ready, 1);
        for (int i = 0; i < 80; i++) busy_plan[i] = 0;
    endtask

    initial begin
        int n;
        for (int i = 0; i < 80; i++) busy_plan[i] = 0;
        repeat (3) @(posedge clock);
        #2;
        check("rst_req_ready", req_ready, 1);
        check("rst_byte_valid", byte_valid, 0);
        check("rst_pkt_valid", pkt_valid, 0);
        check("rst_data_out", data_out, 0);
        check("rst_pl_ready", pl_ready, 0);
        check("rst_done", done, 0);
        check("rst_bad_req", bad_req, 0);
        reset = 1'b0;
        @(posedge clock);
        #2;

        // Basic packet
        pay_q = '{8'h11, 8'h22, 8'h33};
        send_pkt(2'd1, 6'd3, 1'b0);
        wait_done();
        check("basic_parity_literal", last_par, 8'h0D);
        check("basic_bv_cycles", bv_cycles, 5);
        $display("basic packet: bytes=%0d parity=%02h", bv_cycles, last_par);

        // Zero-length packet
        pl_ready_cycles = 0;
        pay_q.delete();
        send_pkt(2'd2, 6'd0, 1'b0);
        wait_done();
        check("zero_parity_literal", last_par, 8'h02);
        check("zero_bv_cycles", bv_cycles, 2);
        check("zero_pl_ready_never", pl_ready_cycles, 0);
        $display("zero-length packet: bytes=%0d parity=%02h", bv_cycles, last_par);

        // Back-pressure: 3 cycles on header, 2 on byte 22
        busy_plan[0] = 3;
        busy_plan[2] = 2;
        pay_q = '{8'h11, 8'h22, 8'h33};
        send_pkt(2'd1, 6'd3, 1'b0);
        wait_done();
        check("bp_parity_literal", last_par, 8'h0D);
        check("bp_bv_cycles", bv_cycles, 10);
        $display("back-pressure packet: bytes=%0d parity=%02h", bv_cycles, last_par);

        // Illegal address
        pl_ready_cycles = 0;
        pay_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        send_pkt(2'd3, 6'd5, 1'b0);
        check("illegal_req_ready", req_ready, 1);
        repeat (6) @(posedge clock);
        #2;
        check("illegal_bv_cycles", bv_cycles, 0);
        check("illegal_pl_ready_never", pl_ready_cycles, 0);
        check("illegal_req_ready_later", req_ready, 1);
        $display("illegal request: bytes=%0d pl_ready_cycles=%0d", bv_cycles, pl_ready_cycles);

        // Reset mid-payload after byte 11 consumed
        pay_q = '{8'h11, 8'h22, 8'h33};
        send_pkt(2'd1, 6'd3, 1'b0);
        n = 0;
        while (byte_idx < 2 && n < 200) begin
            @(posedge clock);
            n++;
        end
        if (byte_idx < 2) check("abort_wait_timeout", byte_idx, 2);
        #2;
        reset = 1'b1;
        @(posedge clock);
        #2;
        reset = 1'b0;
        exp_q.delete();
        @(negedge clock);
        check("abort_pkt_valid", pkt_valid, 0);
        check("abort_byte_valid", byte_valid, 0);
        check("abort_req_ready", req_ready, 1);
        $display("reset mid-payload: pkt_valid=%0b byte_valid=%0b req_ready=%0b", pkt_valid, byte_valid, req_ready);
        @(posedge clock);
        #2;
        pay_q = '{8'hAA};
        send_pkt(2'd0, 6'd1, 1'b0);
        wait_done();
        check("post_abort_parity_literal", last_par, 8'hAE);
        check("post_abort_bv_cycles", bv_cycles, 3);
        $display("post-abort packet: bytes=%0d parity=%02h", bv_cycles, last_par);

`ifdef PKT_TX_PARITY_ERR_EN
        pay_q = '{8'h11, 8'h22, 8'h33};
        send_pkt(2'd1, 6'd3, 1'b1);
        wait_done();
        check("corrupt_parity_literal", last_par, 8'h0C);
        $display("corrupted-parity packet: bytes=%0d parity=%02h", bv_cycles, last_par);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "global timeout");
    end

endmodule
